line_tx: RTL and testbench



---
 rtl/line_tx_pkg.sv | 9 +
 rtl/line_tx_bit_timer.sv | 27 ++
 rtl/line_tx.sv | 134 +++++++++++++
 tb/tb_line_tx.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/line_tx_pkg.sv
// Shared types and constants for the line_tx serial transmitter.
package line_tx_pkg;

    typedef enum logic [1:0] {IDLE, PRE, DATA, GAP} line_tx_state_t;

    localparam int BYTE_W      = 8;
    localparam int MIN_BIT_LEN = 2;

endpackage

// File: rtl/line_tx_bit_timer.sv
// Bit-period counter: counts 0..len_i-1 and flags the final cycle of each period.
module bit_timer #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clr_i,
    input  logic [W-1:0] len_i,
    output logic         tick_o
);

    logic [W-1:0] cnt;

    // Equality compare only, so a period of 2^W-1 never needs a count past len_i-1.
    assign tick_o = (cnt == len_i - W'(1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt <= '0;
        end else if (clr_i || tick_o) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/line_tx.sv
// Serial line transmitter: training preamble, back-to-back MSB-first NRZ bytes, idle gap.
module line_tx
    import line_tx_pkg::*;
#(
    parameter int W = 32,
    parameter int P = 16,
    parameter int G = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [W-1:0] bit_len_i,
    input  logic [7:0]   data_i,
    input  logic         valid_i,
    output logic         ready_o,
    output logic         data_o,
    output logic         busy_o
);

    localparam int PCW = (P > 1) ? $clog2(P) : 1;
    localparam int GCW = (G > 1) ? $clog2(G) : 1;
    localparam int ICW = $clog2(BYTE_W);

    line_tx_state_t      state, state_n;
    logic [PCW-1:0]      pre_cnt, pre_cnt_n;
    logic [GCW-1:0]      gap_cnt, gap_cnt_n;
    logic [ICW-1:0]      idx, idx_n;
    logic [BYTE_W-1:0]   shreg, shreg_n;
    logic [W-1:0]        len, len_n;
    logic                data_n;
    logic                tick;
    logic                clr;

    // Every state change restarts the bit period so each line bit is exactly len cycles.
    assign clr    = (state_n != state);
    assign busy_o = (state != IDLE);

    bit_timer #(.W(W)) u_timer (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (clr),
        .len_i   (len),
        .tick_o  (tick)
    );

    // Handshake: a byte is taken on any cycle where valid_i & ready_o; ready_o is
    // high throughout IDLE and only on the final cycle of the last bit in DATA.
    always_comb begin
        state_n   = state;
        pre_cnt_n = pre_cnt;
        gap_cnt_n = gap_cnt;
        idx_n     = idx;
        shreg_n   = shreg;
        len_n     = len;
        ready_o   = 1'b0;
        data_n    = 1'b0;

        case (state)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    shreg_n   = data_i;
                    len_n     = (bit_len_i < W'(MIN_BIT_LEN)) ? W'(MIN_BIT_LEN) : bit_len_i;
                    pre_cnt_n = '0;
                    state_n   = PRE;
                end
            end
            PRE: begin
                if (tick) begin
                    if (pre_cnt == PCW'(P - 1)) begin
                        idx_n   = ICW'(BYTE_W - 1);
                        state_n = DATA;
                    end else begin
                        pre_cnt_n = pre_cnt + PCW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx == '0) begin
                        ready_o = 1'b1;
                        if (valid_i) begin
                            shreg_n = data_i;
                            idx_n   = ICW'(BYTE_W - 1);
                        end else begin
                            gap_cnt_n = '0;
                            state_n   = GAP;
                        end
                    end else begin
                        shreg_n = shreg << 1;
                        idx_n   = idx - ICW'(1);
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (gap_cnt == GCW'(G - 1)) begin
                        state_n = IDLE;
                    end else begin
                        gap_cnt_n = gap_cnt + GCW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // The line register follows the next state, so data_o lines up with state.
        case (state_n)
            PRE:     data_n = ~pre_cnt_n[0];
            DATA:    data_n = shreg_n[BYTE_W-1];
            default: data_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= IDLE;
            pre_cnt <= '0;
            gap_cnt <= '0;
            idx     <= '0;
            shreg   <= '0;
            len     <= W'(MIN_BIT_LEN);
            data_o  <= 1'b0;
        end else begin
            state   <= state_n;
            pre_cnt <= pre_cnt_n;
            gap_cnt <= gap_cnt_n;
            idx     <= idx_n;
            shreg   <= shreg_n;
            len     <= len_n;
            data_o  <= data_n;
        end
    end

endmodule

// File: tb/tb_line_tx.sv
// Self-checking bench for line_tx: cycle-accurate expected line trace built from frame rules.
module tb_line_tx;

    localparam int W = 32;
    localparam int P = 16;
    localparam int G = 4;

    logic         clk_i;
    logic         rst_n_i;
    logic [W-1:0] bit_len_i;
    logic [7:0]   data_i;
    logic         valid_i;
    logic         ready_o;
    logic         data_o;
    logic         busy_o;

    int n_assert;
    int n_fail;
    int cyc;

    typedef struct {
        logic         d;
        logic         b;
        logic         r;
        logic         v;
        logic [7:0]   din;
        logic [W-1:0] len;
    } step_t;

    step_t      tr[$];
    logic [7:0] frame_bytes[$];

    line_tx #(.W(W), .P(P), .G(G)) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .bit_len_i (bit_len_i),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .data_o    (data_o),
        .busy_o    (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @%0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic push(input logic d, input logic b, input logic r, input logic v,
                        input logic [7:0] din, input logic [W-1:0] len);
        step_t s;
        s.d = d; s.b = b; s.r = r; s.v = v; s.din = din; s.len = len;
        tr.push_back(s);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) push(1'b0, 1'b0, 1'b1, 1'b0, 8'($urandom), W'($urandom));
    endtask

    // One frame carrying frame_bytes; valid/data/bit_len are randomised wherever they must be ignored.
    task automatic push_frame(input logic [W-1:0] bl);
        int nb;
        int l;
        logic [7:0] by;
        logic last;
        logic v;
        nb = frame_bytes.size();
        l  = (bl < 2) ? 2 : int'(bl);
        push(1'b0, 1'b0, 1'b1, 1'b1, frame_bytes[0], bl);
        for (int c = 0; c < P * l; c++)
            push(((c / l) % 2) == 0, 1'b1, 1'b0, 1'($urandom), 8'($urandom), W'($urandom));
        for (int k = 0; k < nb; k++) begin
            by = frame_bytes[k];
            for (int i = 0; i < 8; i++) begin
                for (int r = 0; r < l; r++) begin
                    last = (i == 7) && (r == l - 1);
                    if (last) begin
                        v = (k < nb - 1);
                        push(by[7 - i], 1'b1, 1'b1, v, v ? frame_bytes[k + 1] : 8'($urandom), W'($urandom));
                    end else begin
                        push(by[7 - i], 1'b1, 1'b0, 1'($urandom), 8'($urandom), W'($urandom));
                    end
                end
            end
        end
        // First gap cycle always carries a late valid, which must be ignored.
        for (int c = 0; c < G * l; c++)
            push(1'b0, 1'b1, 1'b0, (c == 0) ? 1'b1 : 1'($urandom), 8'($urandom), W'($urandom));
        frame_bytes.delete();
    endtask

    task automatic run_steps(input int n);
        step_t s;
        for (int i = 0; i < n && tr.size() > 0; i++) begin
            s = tr.pop_front();
            @(posedge clk_i);
            #1;
            valid_i   = s.v;
            data_i    = s.din;
            bit_len_i = s.len;
            @(negedge clk_i);
            cyc++;
            chk("data_o", data_o, s.d);
            chk("busy_o", busy_o, s.b);
            chk("ready_o", ready_o, s.r);
        end
    endtask

    task automatic run_all();
        run_steps(tr.size());
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        cyc       = 0;
        rst_n_i   = 1'b0;
        valid_i   = 1'b0;
        data_i    = '0;
        bit_len_i = W'(4);

        #1;
        chk("rst_data", data_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_ready", ready_o, 1'b1);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        push_idle(3);

        // Single byte 0xA5 at 4 cycles per bit.
        frame_bytes.push_back(8'hA5);
        push_frame(W'(4));
        push_idle(2);

        // Back-to-back 0xFF then 0x00 at 3 cycles per bit.
        frame_bytes.push_back(8'hFF);
        frame_bytes.push_back(8'h00);
        push_frame(W'(3));
        push_idle(1);

        // Clamp of 0 and 1 to a 2-cycle bit; second frame starts on the first IDLE cycle.
        frame_bytes.push_back(8'h3C);
        push_frame(W'(0));
        frame_bytes.push_back(8'hC3);
        push_frame(W'(1));
        push_idle(1);

        // Long period as the receiver sees it in loopback.
        frame_bytes.push_back(8'h96);
        frame_bytes.push_back(8'h5A);
        push_frame(W'(10));
        push_idle(2);
        run_all();

        // Random frames: byte count, period and inter-frame idle all vary.
        for (int f = 0; f < 6; f++) begin
            int nb;
            nb = $urandom_range(1, 3);
            for (int k = 0; k < nb; k++) frame_bytes.push_back(8'($urandom));
            push_frame(W'($urandom_range(0, 6)));
            push_idle($urandom_range(0, 3));
        end
        run_all();

        // Reset in the middle of data bit 3 of an all-ones byte, then a clean frame.
        frame_bytes.push_back(8'hFF);
        push_frame(W'(4));
        run_steps(1 + P * 4 + 3 * 4 + 2);
        chk("pre_rst_data", data_o, 1'b1);
        rst_n_i = 1'b0;
        valid_i = 1'b0;
        #1;
        chk("mid_rst_data", data_o, 1'b0);
        chk("mid_rst_busy", busy_o, 1'b0);
        chk("mid_rst_ready", ready_o, 1'b1);
        tr.delete();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        push_idle(2);
        frame_bytes.push_back(8'h81);
        push_frame(W'(5));
        push_idle(2);
        run_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
